codec_tx: RTL

CODEC_TX -- requirements
Module: codec_tx

---
 rtl/codec_pkg.sv | 23 ++
 rtl/codec_tx_if.sv | 13 +
 rtl/i2s_shift.sv | 37 +++
 rtl/codec_tx.sv | 110 +++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared widths, counter constants and the stereo sample payload for the codec transmitter.
package codec_pkg;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned SMPL_W    = 16;
    localparam int unsigned SLOT_BITS = 32;
    localparam int unsigned PAD_W     = SLOT_BITS - SMPL_W - 1;

    localparam logic [CNT_W-1:0] RST_CNT   = 10'h200;
    localparam logic [CNT_W-1:0] CNT_LAST  = 10'h3FF;
    localparam logic [CNT_W-1:0] HALF_LAST = 10'h1FF;

    typedef struct packed {
        logic [SMPL_W-1:0] lft;
        logic [SMPL_W-1:0] rht;
    } stereo_t;

    // I2S slot image: one-bit delay, sample MSB first, zero padding.
    function automatic logic [SLOT_BITS-1:0] slot_word(input logic [SMPL_W-1:0] s);
        return {1'b0, s, {PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/codec_tx_if.sv
// Sample-pair valid/ready bus between the producer and the codec transmitter.
interface codec_tx_if;
    import codec_pkg::*;

    logic [SMPL_W-1:0] lft_smpl;
    logic [SMPL_W-1:0] rht_smpl;
    logic              smpl_vld;
    logic              smpl_rdy;

    modport master (output lft_smpl, output rht_smpl, output smpl_vld, input smpl_rdy);
    modport slave  (input lft_smpl, input rht_smpl, input smpl_vld, output smpl_rdy);

endinterface

// File: rtl/i2s_shift.sv
// 32-bit load/shift register; serial output is the MSB, zero fill from the bottom.
module i2s_shift
    import codec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [SLOT_BITS-1:0] load_val_i,
    output logic                 sdo_o
);

    logic [SLOT_BITS-1:0] sr_q;
    logic [SLOT_BITS-1:0] sr_d;

    // Load wins over shift so a slot start never loses its new word.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[SLOT_BITS-2:0], 1'b0};
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sdo_o = sr_q[SLOT_BITS-1];

endmodule

// File: rtl/codec_tx.sv
// I2S stereo transmitter: clock divider, one-pair holding buffer and serializer.
module codec_tx
    import codec_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    codec_tx_if.slave  smpl_if,
    output logic       MCLK,
    output logic       SCLK,
    output logic       LRCLK,
    output logic       SDin,
    output logic       frm_start,
    output logic       underrun
);

    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    stereo_t              buf_q;
    stereo_t              buf_d;
    logic                 full_q;
    logic                 full_d;
    logic [SMPL_W-1:0]    rht_q;
    logic [SMPL_W-1:0]    rht_d;
    logic                 rdy_q;
    logic                 rdy_d;
    logic                 frm_q;
    logic                 und_q;

    logic                 frame_start_c;
    logic                 half_start_c;
    logic                 bit_edge_c;
    logic                 accept_c;
    logic                 sr_load_c;
    logic [SLOT_BITS-1:0] sr_val_c;

    // Events are decoded on the cycle before the counter edge they name.
    assign frame_start_c = (cnt_q == CNT_LAST);
    assign half_start_c  = (cnt_q == HALF_LAST);
    assign bit_edge_c    = &cnt_q[3:0];
    assign accept_c      = smpl_if.smpl_vld & rdy_q;

    // Next-state for counter, buffer, latched right word and ready.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        buf_d     = buf_q;
        full_d    = full_q;
        rht_d     = rht_q;
        sr_load_c = 1'b0;
        sr_val_c  = '0;
        if (frame_start_c) begin
            sr_load_c = 1'b1;
            if (full_q) begin
                sr_val_c = slot_word(buf_q.lft);
                rht_d    = buf_q.rht;
                full_d   = 1'b0;
            end else begin
                rht_d    = '0;
            end
        end else if (half_start_c) begin
            sr_load_c = 1'b1;
            sr_val_c  = slot_word(rht_q);
        end
        // A refill on the transfer cycle overrides the clear above.
        if (accept_c) begin
            buf_d.lft = smpl_if.lft_smpl;
            buf_d.rht = smpl_if.rht_smpl;
            full_d    = 1'b1;
        end
        // Ready is precomputed so it is a flop: not full, or a transfer is due.
        rdy_d = ~full_d | (cnt_d == CNT_LAST);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RST_CNT;
            buf_q  <= '0;
            full_q <= 1'b0;
            rht_q  <= '0;
            rdy_q  <= 1'b1;
            frm_q  <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            buf_q  <= buf_d;
            full_q <= full_d;
            rht_q  <= rht_d;
            rdy_q  <= rdy_d;
            frm_q  <= frame_start_c;
            und_q  <= frame_start_c & ~full_q;
        end
    end

    i2s_shift u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (sr_load_c),
        .shift_i    (bit_edge_c),
        .load_val_i (sr_val_c),
        .sdo_o      (SDin)
    );

    assign MCLK             = cnt_q[1];
    assign SCLK             = cnt_q[3];
    assign LRCLK            = cnt_q[CNT_W-1];
    assign frm_start        = frm_q;
    assign underrun         = und_q;
    assign smpl_if.smpl_rdy = rdy_q;

endmodule
